// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : alu_pkg                                                      |
// | Purpose : Shared types and constants for the 4-bit alu issue stage.    |
// |           Opcode enum, request struct and output-register FSM states.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package alu_pkg;

    localparam int OPW  = 4;    // operand width, matches alu OP1/OP2
    localparam int OPCW = 3;    // opcode width, matches alu OPCODE

    typedef enum logic [OPCW-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e          opcode;
        logic [OPW-1:0]   op1;
        logic [OPW-1:0]   op2;
    } alu_req_t;

    // State of the output register towards the alu.
    //   IDLE  : nothing presented
    //   ISSUE : a request was loaded at the last edge
    //   HOLD  : the presented request was not consumed and is being held
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } issue_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_issue_fifo                                               |
// | Purpose : DEPTH x alu_req_t request storage with read/write pointers,  |
// |           occupancy counter and full/empty flags.                      |
// | Ports   : clk, rst (async, active-high), flush (sync clear)            |
// |           push/push_data  - write tail entry when not full             |
// |           pop/head_data   - advance head when not empty                |
// |           occupancy, full, empty                                       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  alu_req_t                  push_data,
    input  logic                      pop,
    output alu_req_t                  head_data,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_req_t             mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic                 do_push;
    logic                 do_pop;

    // Full/empty are decoded from the occupancy count rather than from a
    // pointer compare, so equal pointers never need disambiguating.
    assign full      = (occ_q == CNT_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign head_data = mem[rd_ptr_q];

    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // Pointers wrap naturally: DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      occ_d = occ_q + CNT_W'(1);
            else if (do_pop && !do_push) occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule : alu_issue_fifo
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_issue_queue                                              |
// | Purpose : Issue stage for the 4-bit alu. Buffers {opcode,op1,op2}      |
// |           requests in a FIFO and presents one registered request per   |
// |           cycle on the alu pins under valid/ready.                     |
// | Ports   : clk, rst (async, active-high), flush (sync discard)          |
// |           in_valid/in_ready/in_opcode/in_op1/in_op2  - sequencer side  |
// |           alu_valid/alu_ready/alu_opcode/alu_op1/alu_op2 - alu side    |
// |           occupancy  - FIFO entries, output register excluded          |
// |           issue_cnt/stall_cnt - only with ALU_ISSUE_STATS_EN defined   |
// | Macro   : ALU_ISSUE_STATS_EN enables the handshake/stall counters.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCW-1:0]           in_opcode,
    input  logic [OPW-1:0]            in_op1,
    input  logic [OPW-1:0]            in_op2,
    input  logic                      flush,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [OPCW-1:0]           alu_opcode,
    output logic [OPW-1:0]            alu_op1,
    output logic [OPW-1:0]            alu_op2,
    output logic [$clog2(DEPTH):0]    occupancy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]               issue_cnt,
    output logic [15:0]               stall_cnt
`endif
);

    alu_req_t      in_req;
    alu_req_t      head_req;
    alu_req_t      out_q, out_d;
    issue_state_e  state_q, state_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign in_req = '{opcode: alu_op_e'(in_opcode), op1: in_op1, op2: in_op2};

    // in_ready comes from registered occupancy only, so a pop in the full
    // cycle cannot reopen it until the following cycle.
    assign in_ready  = ~fifo_full;
    assign push      = in_valid & ~fifo_full & ~flush;
    // The output register can take a new request when it is empty or its
    // current request is being consumed this cycle.
    assign pop       = ~fifo_empty & (~alu_valid | alu_ready) & ~flush;

    assign alu_valid  = (state_q != IDLE);
    assign alu_opcode = out_q.opcode;
    assign alu_op1    = out_q.op1;
    assign alu_op2    = out_q.op2;

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .head_data (head_req),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output register FSM. Data is only reloaded on a pop or cleared on
    // flush, so it stays bit-stable in HOLD and keeps its last value in IDLE.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (flush) begin
            state_d = IDLE;
            out_d   = '0;
        end else if (pop) begin
            state_d = ISSUE;
            out_d   = head_req;
        end else begin
            case (state_q)
                ISSUE, HOLD: state_d = alu_ready ? IDLE : HOLD;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counters observe the alu handshake as it happens; flush does not
    // clear them.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (alu_valid && alu_ready && issue_cnt_q != 16'hFFFF)
            issue_cnt_d = issue_cnt_q + 16'd1;
        if (alu_valid && !alu_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule : alu_issue_queue
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_alu_issue_queue                                           |
// | Purpose : Self-checking bench for alu_issue_queue. Directed sequences  |
// |           plus random traffic, compared each cycle against a queue     |
// |           based reference model. ALU_ISSUE_STATS_EN adds counter       |
// |           checks.                                                      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [3:0]  in_op1;
    logic [3:0]  in_op2;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_op1;
    logic [3:0]  alu_op2;
    logic [2:0]  occupancy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
`endif

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .occupancy  (occupancy)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] opc;
        logic [3:0] a;
        logic [3:0] b;
    } mreq_t;

    mreq_t       m_q[$];
    logic        m_valid;
    mreq_t       m_out;
    int unsigned m_issue;
    int unsigned m_stall;

    int n_total;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_out   = '{opc: 3'd0, a: 4'd0, b: 4'd0};
        m_issue = 0;
        m_stall = 0;
    endtask

    // Apply one clock edge worth of behaviour using the inputs as sampled.
    task automatic model_edge();
        bit    accept;
        mreq_t r;
        accept = in_valid && (m_q.size() < DEPTH);
        if (m_valid && alu_ready && m_issue < 16'hFFFF) m_issue++;
        if (m_valid && !alu_ready && m_stall < 16'hFFFF) m_stall++;
        if (flush) begin
            m_q.delete();
            m_valid = 1'b0;
            m_out   = '{opc: 3'd0, a: 4'd0, b: 4'd0};
        end else begin
            if (m_q.size() > 0 && (!m_valid || alu_ready)) begin
                m_out   = m_q.pop_front();
                m_valid = 1'b1;
            end else if (m_valid && alu_ready) begin
                m_valid = 1'b0;
            end
            if (accept) begin
                r = '{opc: in_opcode, a: in_op1, b: in_op2};
                m_q.push_back(r);
            end
        end
    endtask

    task automatic check_all();
        check("alu_valid",  {31'd0, alu_valid}, {31'd0, m_valid});
        check("alu_opcode", {29'd0, alu_opcode}, {29'd0, m_out.opc});
        check("alu_op1",    {28'd0, alu_op1}, {28'd0, m_out.a});
        check("alu_op2",    {28'd0, alu_op2}, {28'd0, m_out.b});
        check("occupancy",  {29'd0, occupancy}, m_q.size());
        check("in_ready",   {31'd0, in_ready}, {31'd0, (m_q.size() < DEPTH)});
`ifdef ALU_ISSUE_STATS_EN
        check("issue_cnt",  {16'd0, issue_cnt}, m_issue);
        check("stall_cnt",  {16'd0, stall_cnt}, m_stall);
`endif
    endtask

    // Drive one cycle of inputs, step DUT and model, then compare.
    task automatic cyc(input logic v, input logic [2:0] opc, input logic [3:0] a,
                       input logic [3:0] b, input logic rdy, input logic fl);
        in_valid  = v;
        in_opcode = opc;
        in_op1    = a;
        in_op2    = b;
        alu_ready = rdy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_opcode = 3'd0;
        in_op1    = 4'd0;
        in_op2    = 4'd0;
        alu_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] held_op1;
        logic [3:0] held_op2;
        logic [2:0] held_opc;
        n_total = 0;
        n_bad   = 0;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_valid",    {31'd0, alu_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with the alu stalled: the first request reaches the output
        // register, the rest stack up in the FIFO.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 3'b001, 4'(i), 4'd8, 1'b0, 1'b0);
        check("fill_occ",   {29'd0, occupancy}, 32'd3);
        check("fill_valid", {31'd0, alu_valid}, 32'd1);
        check("fill_op1",   {28'd0, alu_op1},   32'd1);
        cyc(1'b1, 3'b001, 4'd5, 4'd8, 1'b0, 1'b0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        cyc(1'b1, 3'b001, 4'd6, 4'd8, 1'b0, 1'b0);   // rejected while full
        for (int i = 0; i < 6; i++) cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        check("drained_valid", {31'd0, alu_valid}, 32'd0);

        // Single push into an empty queue, then a 3-cycle stall.
        cyc(1'b1, 3'b010, 4'hF, 4'h1, 1'b0, 1'b0);
        check("lat_valid_early", {31'd0, alu_valid}, 32'd0);
        cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check("lat_valid",  {31'd0, alu_valid}, 32'd1);
        check("lat_opcode", {29'd0, alu_opcode}, 32'd2);
        check("lat_op1",    {28'd0, alu_op1},    32'hF);
        check("lat_op2",    {28'd0, alu_op2},    32'h1);
        held_opc = alu_opcode;
        held_op1 = alu_op1;
        held_op2 = alu_op2;
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check("hold_op1", {28'd0, alu_op1}, {28'd0, held_op1});
        check("hold_op2", {28'd0, alu_op2}, {28'd0, held_op2});
        check("hold_opc", {29'd0, alu_opcode}, {29'd0, held_opc});
        cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0);

        // Streaming push/pop pairs across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 3'(i), 4'(i + 3), 4'(15 - i), 1'b1, 1'b0);
            check("stream_occ_le1", {31'd0, (occupancy <= 3'd1)}, 32'd1);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0);

        // Flush with two queued requests and a simultaneous push.
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'b100, 4'(i), 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 3'b111, 4'hA, 4'hB, 1'b0, 1'b1);
        check("flush_occ",   {29'd0, occupancy}, 32'd0);
        check("flush_valid", {31'd0, alu_valid}, 32'd0);
        check("flush_op1",   {28'd0, alu_op1},   32'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom),
                1'(($urandom % 4) != 0 ? (i % 64 < 40) : $urandom_range(0, 1)),
                1'(($urandom % 25) == 0));
        end

        // Asynchronous reset in the middle of a HOLD.
        cyc(1'b1, 3'b011, 4'h7, 4'h9, 1'b0, 1'b0);
        cyc(1'b1, 3'b011, 4'h6, 4'h5, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, alu_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_op1",   {28'd0, alu_op1},   32'd0);
        check("rst_valid", {31'd0, alu_valid}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 3'b110, 4'h3, 4'h4, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_alu_issue_queue
`default_nettype wire
